// File: rtl/pkt_tx_pkg.sv
// ============================================================================
// pkt_tx_pkg
// Shared definitions for the packet transmit drain stage: FSM encoding,
// default bus widths and the skid buffer geometry.
// ============================================================================
package pkt_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DRAIN = 2'b10
    } tx_state_e;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_ADDR_W = 8;

    // Two entries cover the one-cycle RAM latency plus one word parked while
    // the downstream stalls.
    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/pkt_tx_if.sv
// ============================================================================
// pkt_tx_if
// Groups the packet memory read port and the downstream output bus of the
// transmit engine.
//   master : engine side  (drives read address/strobe and the output word)
//   slave  : environment  (packet memory + downstream consumer)
// Signals:
//   mem_rd_addr / mem_rd_en   read request, data returns one cycle later
//   mem_rd_data / mem_rd_ctrl read response
//   out_rdy                   downstream can take a word this cycle
//   out_wr / out_ctrl / out_data  emitted word
// ============================================================================
interface pkt_tx_if
    import pkt_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rd_data;
    logic [CTRL_W-1:0] mem_rd_ctrl;
    logic              out_rdy;
    logic              out_wr;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output mem_rd_addr, mem_rd_en, out_wr, out_ctrl, out_data,
        input  mem_rd_data, mem_rd_ctrl, out_rdy
    );

    modport slave (
        input  mem_rd_addr, mem_rd_en, out_wr, out_ctrl, out_data,
        output mem_rd_data, mem_rd_ctrl, out_rdy
    );
endinterface

// File: rtl/pkt_tx_skid.sv
// ============================================================================
// pkt_tx_skid
// Two-entry FIFO of {ctrl,data} words sitting between the packet RAM output
// and the downstream bus. When empty, an incoming word is visible on head in
// the same cycle and can be popped straight through without being stored.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   push         a RAM word is arriving this cycle (push_word)
//   pop          the head word is consumed this cycle (only when avail)
//   head         current head word (stored head, or push_word when empty)
//   avail        a word is presentable this cycle (stored or arriving)
//   count        number of stored words
// ============================================================================
module pkt_tx_skid
    import pkt_tx_pkg::*;
#(
    parameter int WORD_W = DEF_CTRL_W + DEF_DATA_W
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WORD_W-1:0]     push_word,
    input  logic                  pop,
    output logic [WORD_W-1:0]     head,
    output logic                  avail,
    output logic [SKID_CNT_W-1:0] count
);
    logic [WORD_W-1:0]     mem [SKID_DEPTH];
    logic                  wr_idx;
    logic                  rd_idx;
    logic [SKID_CNT_W-1:0] count_q;
    logic                  empty;
    logic                  bypass;
    logic                  wr_en;
    logic                  rd_en;

    assign empty  = (count_q == '0);
    // Empty buffer with a word arriving and being taken: pass it through.
    assign bypass = push & pop & empty;
    assign wr_en  = push & ~bypass;
    assign rd_en  = pop & ~empty;

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx  <= 1'b0;
            rd_idx  <= 1'b0;
            count_q <= '0;
        end else begin
            if (wr_en) wr_idx <= ~wr_idx;
            if (rd_en) rd_idx <= ~rd_idx;
            count_q <= count_q + SKID_CNT_W'(wr_en) - SKID_CNT_W'(rd_en);
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which
    // entries are valid, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= push_word;
    end

    assign head  = empty ? push_word : mem[rd_idx];
    assign avail = ~empty | push;
    assign count = count_q;

endmodule

// File: rtl/pkt_tx_engine.sv
// ============================================================================
// pkt_tx_engine
// Drain stage of the packet buffer. On tx_start it reads words start..end
// (inclusive, wrapping modulo 2**ADDR_W) from the synchronous-read packet
// memory and emits them in order on the out_* bus under the out_rdy
// handshake. A read is only issued when the skid has room for it, so a stall
// never loses or repeats a word.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   tx_start, tx_start_addr,
//   tx_end_addr                     packet request (sampled only when idle)
//   bus (pkt_tx_if.master)          memory read port + output word bus
//   tx_busy                         packet in progress (incl. start cycle)
//   tx_done                         one-cycle pulse after the last word
// Optional build macro TX_STATS_EN adds stat_pkt_cnt / stat_word_cnt
// (32-bit wrapping counters of tx_done pulses and emitted words).
// ============================================================================
module pkt_tx_engine
    import pkt_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int ADDR_W = DEF_ADDR_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_start,
    input  logic [ADDR_W-1:0] tx_start_addr,
    input  logic [ADDR_W-1:0] tx_end_addr,
    pkt_tx_if.master          bus,
    output logic              tx_busy,
    output logic              tx_done
`ifdef TX_STATS_EN
    ,
    output logic [31:0]       stat_pkt_cnt,
    output logic [31:0]       stat_word_cnt
`endif
);
    localparam int WORD_W = CTRL_W + DATA_W;

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [ADDR_W-1:0]     rd_ptr_q;
    logic [ADDR_W-1:0]     end_q;
    logic                  inflight_q;
    logic [WORD_W-1:0]     last_q;

    logic                  issue;
    logic                  last_rd;
    logic                  drained;
    logic [WORD_W-1:0]     skid_head;
    logic                  skid_avail;
    logic [SKID_CNT_W-1:0] skid_count;
    logic                  out_wr_int;

    // A read may only go out if its data is guaranteed a skid slot.
    assign issue   = (state_q == FETCH) &&
                     ((int'(skid_count) + int'(inflight_q)) < SKID_DEPTH);
    assign last_rd = (rd_ptr_q == end_q);
    assign drained = (skid_count == '0) && !inflight_q;

    assign out_wr_int = bus.out_rdy & skid_avail;

    pkt_tx_skid #(.WORD_W(WORD_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_word ({bus.mem_rd_ctrl, bus.mem_rd_data}),
        .pop       (out_wr_int),
        .head      (skid_head),
        .avail     (skid_avail),
        .count     (skid_count)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_start)          state_d = FETCH;
            FETCH:   if (issue && last_rd)  state_d = DRAIN;
            DRAIN:   if (drained)           state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.mem_rd_en   = issue;
        bus.mem_rd_addr = rd_ptr_q;
        tx_busy         = (state_q != IDLE) || tx_start;
        tx_done         = (state_q == DRAIN) && drained;
        bus.out_wr      = out_wr_int;
        {bus.out_ctrl, bus.out_data} = out_wr_int ? skid_head : last_q;
    end

    // ---------------- Datapath ----------------
    // inflight_q marks that the RAM returns data this cycle; clearing it on
    // reset discards any read issued just before an abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            end_q      <= '0;
            inflight_q <= 1'b0;
            last_q     <= '0;
        end else begin
            inflight_q <= issue;
            if (state_q == IDLE && tx_start) begin
                rd_ptr_q <= tx_start_addr;
                end_q    <= tx_end_addr;
            end else if (issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (out_wr_int) last_q <= skid_head;
        end
    end

`ifdef TX_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_pkt_cnt  <= '0;
            stat_word_cnt <= '0;
        end else begin
            if (tx_done)    stat_pkt_cnt  <= stat_pkt_cnt + 32'd1;
            if (out_wr_int) stat_word_cnt <= stat_word_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_tx_engine.sv
// ============================================================================
// tb_pkt_tx_engine
// Scoreboard bench for pkt_tx_engine. The stimulus side pushes the expected
// words of each accepted packet (read from a behavioural packet memory by
// address arithmetic) into a queue; a negedge monitor pops and compares each
// emitted word and checks tx_done timing.
// ============================================================================
module tb_pkt_tx_engine;
    import pkt_tx_pkg::*;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_start_addr;
    logic [7:0] tx_end_addr;
    logic       tx_busy;
    logic       tx_done;
`ifdef TX_STATS_EN
    logic [31:0] stat_pkt_cnt;
    logic [31:0] stat_word_cnt;
`endif

    pkt_tx_if bus ();

    pkt_tx_engine dut (
        .clk           (clk),
        .reset         (reset),
        .tx_start      (tx_start),
        .tx_start_addr (tx_start_addr),
        .tx_end_addr   (tx_end_addr),
        .bus           (bus.master),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done)
`ifdef TX_STATS_EN
        ,
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_word_cnt (stat_word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          start_cyc   = 0;
    int          last_beat_cyc = 0;
    int          beats       = 0;
    int          done_cnt    = 0;
    bit          pkt_active  = 0;
    bit          chk_latency = 0;
    bit          rdy_rand    = 0;
    logic [79:0] last_word   = '0;
    logic [79:0] exp_q [$];

    logic [63:0] mem_data [256];
    logic [7:0]  mem_ctrl [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- packet memory model: 1-cycle synchronous read ----------------
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rd_data <= mem_data[bus.mem_rd_addr];
            bus.mem_rd_ctrl <= mem_ctrl[bus.mem_rd_addr];
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin
        bus.out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            last_word = '0;
        end else begin
            if (bus.out_wr) begin
                check("wr_needs_rdy", 80'(bus.out_rdy), 80'd1);
                if (exp_q.size() == 0) begin
                    flag("unexpected_word");
                end else begin
                    check("word", 80'({bus.out_ctrl, bus.out_data}), exp_q.pop_front());
                end
                if (beats == 0 && chk_latency)
                    check("first_beat_latency", 80'(cyc - start_cyc), 80'd2);
                beats++;
                last_beat_cyc = cyc;
                last_word     = 80'({bus.out_ctrl, bus.out_data});
            end else begin
                check("hold_when_idle", 80'({bus.out_ctrl, bus.out_data}), last_word);
            end
            if (tx_done) begin
                check("done_expected", 80'(pkt_active), 80'd1);
                check("done_after_last", 80'(cyc - last_beat_cyc), 80'd1);
                check("done_all_words", 80'(exp_q.size()), 80'd0);
                pkt_active = 0;
                done_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_expected(input logic [7:0] s, input logic [7:0] e);
        logic [7:0] span;
        logic [7:0] a;
        span = e - s;
        for (int i = 0; i <= int'(span); i++) begin
            a = s + 8'(i);
            exp_q.push_back(80'({mem_ctrl[a], mem_data[a]}));
        end
    endtask

    task automatic start_pkt(input logic [7:0] s, input logic [7:0] e, input bit lat);
        @(posedge clk);
        #1;
        tx_start      = 1'b1;
        tx_start_addr = s;
        tx_end_addr   = e;
        start_cyc     = cyc;
        beats         = 0;
        chk_latency   = lat;
        pkt_active    = 1;
        push_expected(s, e);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_pkt_done(input string name);
        int n;
        n = 0;
        while (pkt_active && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pkt_active) begin
            flag({name, "_timeout"});
            pkt_active = 0;
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_wr"},   80'(bus.out_wr), 80'd0);
        check({name, "_out_word"}, 80'({bus.out_ctrl, bus.out_data}), 80'd0);
        check({name, "_rd_en"},    80'(bus.mem_rd_en), 80'd0);
        check({name, "_rd_addr"},  80'(bus.mem_rd_addr), 80'd0);
        check({name, "_busy"},     80'(tx_busy), 80'd0);
        check({name, "_done"},     80'(tx_done), 80'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int busy_cycles;
        int done_before;
        logic [7:0] s;
        int len;

        reset           = 1'b1;
        tx_start        = 1'b0;
        tx_start_addr   = '0;
        tx_end_addr     = '0;
        bus.mem_rd_data = '0;
        bus.mem_rd_ctrl = '0;
        for (int i = 0; i < 256; i++) begin
            mem_data[i] = {$urandom, $urandom};
            mem_ctrl[i] = 8'($urandom);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // T1: four words, ready always high, first beat at start+2
        start_pkt(8'h10, 8'h13, 1);
        wait_pkt_done("t1");
        check("t1_beats", 80'(beats), 80'd4);

        // T2: single word; busy spans start cycle through done cycle
        done_before = done_cnt;
        busy_cycles = 0;
        @(posedge clk);
        #1;
        tx_start      = 1'b1;
        tx_start_addr = 8'h05;
        tx_end_addr   = 8'h05;
        start_cyc     = cyc;
        beats         = 0;
        chk_latency   = 1;
        pkt_active    = 1;
        push_expected(8'h05, 8'h05);
        @(negedge clk);
        if (tx_busy) busy_cycles++;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (tx_busy) busy_cycles++;
        end
        check("t2_busy_cycles", 80'(busy_cycles), 80'd4);
        check("t2_done_pulses", 80'(done_cnt - done_before), 80'd1);
        check("t2_beats", 80'(beats), 80'd1);
        wait_pkt_done("t2");

        // T3: wrapping packet FE,FF,00,01
        start_pkt(8'hFE, 8'h01, 1);
        wait_pkt_done("t3");
        check("t3_beats", 80'(beats), 80'd4);

        // T4: 8 words with random backpressure
        rdy_rand = 1;
        start_pkt(8'h40, 8'h47, 0);
        wait_pkt_done("t4");
        check("t4_beats", 80'(beats), 80'd8);
        rdy_rand = 0;

        // T5: second tx_start during a busy packet is ignored
        start_pkt(8'h60, 8'h63, 1);
        @(posedge clk);
        #1;
        tx_start      = 1'b1;
        tx_start_addr = 8'h80;
        tx_end_addr   = 8'h8F;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        wait_pkt_done("t5");
        repeat (4) @(negedge clk);
        check("t5_beats", 80'(beats), 80'd4);

        // A few random packets with random backpressure
        rdy_rand = 1;
        for (int k = 0; k < 6; k++) begin
            s   = 8'($urandom);
            len = $urandom_range(1, 8);
            start_pkt(s, s + 8'(len - 1), 0);
            wait_pkt_done("rand");
            check("rand_beats", 80'(beats), 80'(len));
        end
        rdy_rand = 0;
        repeat (2) @(posedge clk);

        // T6: abort a 6-word packet after beat 2, then a clean 2-word packet
        done_before = done_cnt;
        start_pkt(8'h30, 8'h35, 1);
        begin
            int n;
            n = 0;
            while (beats < 2 && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (beats < 2) flag("t6_beat2_timeout");
        end
        reset      = 1'b1;
        pkt_active = 0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("t6_reset");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_abort_done", 80'(done_cnt - done_before), 80'd0);
        start_pkt(8'h20, 8'h21, 1);
        wait_pkt_done("t6");
        check("t6_beats", 80'(beats), 80'd2);
        check("t6_done_pulses", 80'(done_cnt - done_before), 80'd1);
`ifdef TX_STATS_EN
        @(negedge clk);
        check("t6_stat_pkt", 80'(stat_pkt_cnt), 80'd1);
        check("t6_stat_word", 80'(stat_word_cnt), 80'd2);
`endif
        repeat (4) @(negedge clk);
        check("final_queue_empty", 80'(exp_q.size()), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "simulation timeout");
    end

endmodule
